// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM
// combinationally and registers the fetched word into IF/ID for decode.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] IRQ_PC   = 32'h8000_0004,
  parameter logic [31:0] EXC_PC   = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [25:0] jump_idx,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        irq,
  input  logic        exc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        irq_taken
);

  // Redirect source chosen this cycle, highest priority first.
  typedef enum logic [2:0] {
    SEL_EXC,
    SEL_IRQ,
    SEL_BR,
    SEL_STALL,
    SEL_JR,
    SEL_JUMP,
    SEL_SEQ
  } sel_e;

  logic [31:0] pc_p0;
  logic [31:0] instr_p1;
  logic [31:0] pc_plus4_p1;
  logic        vld_p1;

  sel_e        sel;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] pc_nxt;
  logic [31:0] instr_nxt;
  logic [31:0] pc_plus4_nxt;
  logic        vld_nxt;
  logic        ifid_en;

  // Bit 31 is the kernel flag; only the low 31 bits advance and wrap.
  function automatic logic [31:0] inc_pc(input logic [31:0] p);
    return {p[31], p[30:0] + 31'd4};
  endfunction

  assign pc_plus4    = inc_pc(pc_p0);
  assign jump_target = {pc_plus4_p1[31:28], jump_idx, 2'b00};

  // Priority encoder over the redirect sources; irq is masked in kernel mode.
  always_comb begin
    sel = SEL_SEQ;
    if (exc)                  sel = SEL_EXC;
    else if (irq && !pc_p0[31]) sel = SEL_IRQ;
    else if (br_taken)        sel = SEL_BR;
    else if (stall)           sel = SEL_STALL;
    else if (jr)              sel = SEL_JR;
    else if (jump)            sel = SEL_JUMP;
  end

  // Next PC and IF/ID contents; every redirect squashes the word fetched now.
  always_comb begin
    pc_nxt       = pc_plus4;
    instr_nxt    = 32'h0;
    pc_plus4_nxt = pc_plus4;
    vld_nxt      = 1'b0;
    ifid_en      = 1'b1;
    case (sel)
      SEL_EXC:   pc_nxt = EXC_PC;
      SEL_IRQ:   pc_nxt = IRQ_PC;
      SEL_BR:    pc_nxt = br_target;
      SEL_STALL: begin
        pc_nxt  = pc_p0;
        ifid_en = 1'b0;
      end
      SEL_JR:    pc_nxt = jr_target;
      SEL_JUMP:  pc_nxt = jump_target;
      SEL_SEQ: begin
        instr_nxt = imem_instr;
        vld_nxt   = 1'b1;
      end
      default: ;
    endcase
  end

  // PC and IF/ID registers (stage boundary IF -> ID).
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0       <= RESET_PC;
      instr_p1    <= 32'h0;
      pc_plus4_p1 <= 32'h0;
      vld_p1      <= 1'b0;
    end else begin
      pc_p0 <= pc_nxt;
      if (ifid_en) begin
        instr_p1    <= instr_nxt;
        pc_plus4_p1 <= pc_plus4_nxt;
        vld_p1      <= vld_nxt;
      end
    end
  end

  assign imem_addr     = pc_p0;
  assign ifid_instr    = instr_p1;
  assign ifid_pc_plus4 = pc_plus4_p1;
  assign ifid_valid    = vld_p1;
  assign irq_taken     = (sel == SEL_IRQ) && !reset;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: reference model feeding a scoreboard queue,
// plus directed scenario tasks with inline checks.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IRQ_PC   = 32'h8000_0004;
  localparam logic [31:0] EXC_PC   = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken, jump, jr, irq, exc;
  logic [31:0] br_target, jr_target;
  logic [25:0] jump_idx;
  logic [31:0] imem_addr, imem_instr, ifid_instr, ifid_pc_plus4;
  logic        ifid_valid, irq_taken;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hC0DE_0000 | {25'd0, a[8:2]};
  endfunction

  assign imem_instr = rom(imem_addr);

  if_stage #(.RESET_PC(RESET_PC), .IRQ_PC(IRQ_PC), .EXC_PC(EXC_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .jump(jump), .jump_idx(jump_idx), .jr(jr),
    .jr_target(jr_target), .irq(irq), .exc(exc), .imem_addr(imem_addr),
    .imem_instr(imem_instr), .ifid_instr(ifid_instr),
    .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid),
    .irq_taken(irq_taken)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        irq_obs;
    logic        irq_exp;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;

  // Drive one cycle: predict the post-edge state, queue it, advance the model.
  task automatic tick();
    exp_t e;
    logic [31:0] p4;
    #1;
    p4 = {m_pc[31], m_pc[30:0] + 31'd4};
    e.irq_obs = irq_taken;
    e.irq_exp = 1'b0;
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
    if (reset) begin
      e.pc = RESET_PC; e.instr = 32'h0; e.pc4 = 32'h0; e.valid = 1'b0;
    end else if (exc) begin
      e.pc = EXC_PC; e.instr = 32'h0; e.pc4 = p4; e.valid = 1'b0;
    end else if (irq && !m_pc[31]) begin
      e.pc = IRQ_PC; e.instr = 32'h0; e.pc4 = p4; e.valid = 1'b0;
      e.irq_exp = 1'b1;
    end else if (br_taken) begin
      e.pc = br_target; e.instr = 32'h0; e.pc4 = p4; e.valid = 1'b0;
    end else if (stall) begin
      e.pc = m_pc;
    end else if (jr) begin
      e.pc = jr_target; e.instr = 32'h0; e.pc4 = p4; e.valid = 1'b0;
    end else if (jump) begin
      e.pc = {m_pc4[31:28], jump_idx, 2'b00};
      e.instr = 32'h0; e.pc4 = p4; e.valid = 1'b0;
    end else begin
      e.pc = p4; e.instr = rom(m_pc); e.pc4 = p4; e.valid = 1'b1;
    end
    q.push_back(e);
    @(posedge clk);
    m_pc = e.pc; m_instr = e.instr; m_pc4 = e.pc4; m_valid = e.valid;
    @(negedge clk);
  endtask

  // Scoreboard: compare each edge's outcome with the queued prediction.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, e.irq_obs} !==
          {e.pc, e.instr, e.pc4, e.valid, e.irq_exp}) begin
        errors++;
        $display("FAIL scoreboard got pc=%h instr=%h pc4=%h v=%b irq=%b expected pc=%h instr=%h pc4=%h v=%b irq=%b",
                 imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, e.irq_obs,
                 e.pc, e.instr, e.pc4, e.valid, e.irq_exp);
      end
    end
  end

  task automatic clear_inputs();
    reset = 0; stall = 0; br_taken = 0; jump = 0; jr = 0; irq = 0; exc = 0;
    br_target = 0; jr_target = 0; jump_idx = 0;
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick(); reset = 0;
    checks++;
    if ({imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, irq_taken} !==
        {32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got pc=%h instr=%h pc4=%h v=%b irq=%b", imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, irq_taken);
    end
    tick();
    checks++;
    if ({imem_addr, ifid_instr, ifid_valid} !== {32'h8000_0004, 32'hC0DE_0000, 1'b1}) begin
      errors++;
      $display("FAIL first_fetch got pc=%h instr=%h v=%b want 80000004 c0de0000 1", imem_addr, ifid_instr, ifid_valid);
    end
  endtask

  task automatic test_jump();
    jr = 1; jr_target = 32'h0000_00fc; tick(); jr = 0;
    tick();
    checks++;
    if ({imem_addr, ifid_pc_plus4} !== {32'h0000_0100, 32'h0000_0100}) begin
      errors++;
      $display("FAIL jump_setup got pc=%h pc4=%h want 00000100 00000100", imem_addr, ifid_pc_plus4);
    end
    jump = 1; jump_idx = 26'h3a; tick(); jump = 0;
    checks++;
    if ({imem_addr, ifid_instr, ifid_valid} !== {32'h0000_00e8, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL jump_target got pc=%h instr=%h v=%b want 000000e8 0 0", imem_addr, ifid_instr, ifid_valid);
    end
    tick();
    checks++;
    if ({ifid_instr, ifid_valid} !== {32'hC0DE_003A, 1'b1}) begin
      errors++;
      $display("FAIL jump_fetch got instr=%h v=%b want c0de003a 1", ifid_instr, ifid_valid);
    end
  endtask

  task automatic test_stall();
    jr = 1; jr_target = 32'h0000_003c; tick(); jr = 0;
    tick();
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid} !==
          {32'h0000_0040, 32'hC0DE_000F, 32'h0000_0040, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got pc=%h instr=%h pc4=%h v=%b", i, imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid);
      end
    end
    stall = 0; tick();
    checks++;
    if ({imem_addr, ifid_instr} !== {32'h0000_0044, 32'hC0DE_0010}) begin
      errors++;
      $display("FAIL stall_release got pc=%h instr=%h want 00000044 c0de0010", imem_addr, ifid_instr);
    end
  endtask

  task automatic test_branch_stall();
    stall = 1; br_taken = 1; br_target = 32'h0000_00d0; tick(); br_taken = 0;
    checks++;
    if ({imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid} !==
        {32'h0000_00d0, 32'h0, 32'h0000_0048, 1'b0}) begin
      errors++;
      $display("FAIL branch_over_stall got pc=%h instr=%h pc4=%h v=%b", imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid);
    end
    jump = 1; jump_idx = 26'h3a; tick(); jump = 0; stall = 0;
    checks++;
    if ({imem_addr, ifid_pc_plus4, ifid_valid} !== {32'h0000_00d0, 32'h0000_0048, 1'b0}) begin
      errors++;
      $display("FAIL jump_under_stall got pc=%h pc4=%h v=%b want 000000d0 00000048 0", imem_addr, ifid_pc_plus4, ifid_valid);
    end
    tick();
  endtask

  task automatic test_irq();
    jr = 1; jr_target = 32'h0000_0080; tick(); jr = 0;
    irq = 1; #1;
    checks++;
    if (irq_taken !== 1'b1) begin
      errors++;
      $display("FAIL irq_pulse got %b want 1", irq_taken);
    end
    tick();
    checks++;
    if ({imem_addr, irq_taken, ifid_valid} !== {32'h8000_0004, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL irq_vector got pc=%h irq=%b v=%b want 80000004 0 0", imem_addr, irq_taken, ifid_valid);
    end
    jr = 1; jr_target = 32'h8000_0100; tick(); jr = 0;
    tick();
    checks++;
    if ({imem_addr, ifid_instr, ifid_valid, irq_taken} !== {32'h8000_0104, 32'hC0DE_0040, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL irq_masked got pc=%h instr=%h v=%b irq=%b", imem_addr, ifid_instr, ifid_valid, irq_taken);
    end
    jr = 1; jr_target = 32'h0000_0080; tick(); jr = 0; irq = 0;
    checks++;
    if (imem_addr !== 32'h0000_0080) begin
      errors++;
      $display("FAIL jr_to_user got pc=%h want 00000080", imem_addr);
    end
  endtask

  task automatic test_exc();
    exc = 1; irq = 1; br_taken = 1; br_target = 32'h0000_00d0; #1;
    checks++;
    if (irq_taken !== 1'b0) begin
      errors++;
      $display("FAIL exc_masks_irq got irq_taken=%b want 0", irq_taken);
    end
    tick(); exc = 0; irq = 0; br_taken = 0;
    checks++;
    if ({imem_addr, ifid_pc_plus4, ifid_valid} !== {32'h8000_0008, 32'h0000_0084, 1'b0}) begin
      errors++;
      $display("FAIL exc_vector got pc=%h pc4=%h v=%b want 80000008 00000084 0", imem_addr, ifid_pc_plus4, ifid_valid);
    end
  endtask

  task automatic test_wrap();
    jr = 1; jr_target = 32'h7fff_fffc; tick(); jr = 0;
    tick();
    checks++;
    if ({imem_addr, ifid_instr, ifid_pc_plus4} !== {32'h0000_0000, 32'hC0DE_007F, 32'h0000_0000}) begin
      errors++;
      $display("FAIL user_wrap got pc=%h instr=%h pc4=%h", imem_addr, ifid_instr, ifid_pc_plus4);
    end
    jr = 1; jr_target = 32'hffff_fffc; tick(); jr = 0;
    tick();
    checks++;
    if (imem_addr !== 32'h8000_0000) begin
      errors++;
      $display("FAIL kernel_wrap got pc=%h want 80000000", imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    tick(); tick();
    reset = 1; exc = 1; irq = 1; br_taken = 1; jump = 1; jr = 1; stall = 1;
    br_target = 32'h0000_0200; jr_target = 32'h0000_0300;
    #1;
    checks++;
    if (irq_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got irq_taken=%b want 0", irq_taken);
    end
    tick();
    clear_inputs();
    checks++;
    if ({imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid} !== {32'h8000_0000, 32'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_override got pc=%h instr=%h pc4=%h v=%b", imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 80; i++) begin
      reset     = ($urandom_range(0, 40) == 0);
      exc       = ($urandom_range(0, 15) == 0);
      irq       = ($urandom_range(0, 6) == 0);
      br_taken  = ($urandom_range(0, 7) == 0);
      stall     = ($urandom_range(0, 5) == 0);
      jr        = ($urandom_range(0, 7) == 0);
      jump      = ($urandom_range(0, 7) == 0);
      br_target = $urandom & 32'hffff_fffc;
      jr_target = $urandom & 32'hffff_fffc;
      jump_idx  = 26'($urandom);
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    reset = 1;
    m_pc = 'x; m_instr = 'x; m_pc4 = 'x; m_valid = 1'bx;
    @(negedge clk);
    test_reset();
    test_jump();
    test_stall();
    test_branch_stall();
    test_irq();
    test_exc();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
